// File: rtl/atu_tune_seq_pkg.sv
// Shared types and helpers for the ATU tune sequencer (package atu_pkg).
// Holds the FSM state encoding, the status codes reported to the host, and
// the width of the millisecond counters used by every timed state.
package atu_pkg;

    // Width of every millisecond counter; 16 bits covers the longest timeout.
    localparam int MS_CNT_W = 16;

    typedef logic [MS_CNT_W-1:0] ms_cnt_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        WAIT_ACK = 3'd2,
        TUNE     = 3'd3,
        COOL     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ST_NONE    = 2'd0,
        ST_OK      = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_ABORT   = 2'd3
    } status_t;

    // Saturating increment: a counter parked at all-ones stays there.
    function automatic ms_cnt_t ms_sat_inc(input ms_cnt_t v);
        if (v == '1) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // Counter value at which the next tick completes a duration of 'ms'.
    // The counter starts at zero on state entry, so the final tick is the
    // one seen while the counter already holds ms-1.
    function automatic ms_cnt_t ms_limit(input int ms);
        if (ms <= 1) begin
            return '0;
        end
        if (ms > (1 << MS_CNT_W)) begin
            return '1;
        end
        return ms_cnt_t'(ms - 1);
    endfunction

endpackage

// File: rtl/atu_tune_seq_if.sv
// Command and tuner-pin bundle for the ATU tune sequencer.
// master: command decoder / pin side that drives requests and the raw key line.
// slave:  the sequencer, which drives the start line, carrier request and status.
interface atu_tune_seq_if;

    logic       tune_start;
    logic       tune_abort;
    logic       tx_inhibit;
    logic       atu_ack;
    logic       atu_req;
    logic       tx_tune_en;
    logic       busy;
    logic [1:0] status;

    modport master (
        output tune_start,
        output tune_abort,
        output tx_inhibit,
        output atu_ack,
        input  atu_req,
        input  tx_tune_en,
        input  busy,
        input  status
    );

    modport slave (
        input  tune_start,
        input  tune_abort,
        input  tx_inhibit,
        input  atu_ack,
        output atu_req,
        output tx_tune_en,
        output busy,
        output status
    );

endinterface

// File: rtl/atu_tune_seq_ms_tick.sv
// Free-running millisecond prescaler: one-cycle tick every CLK_HZ/1000 clocks.
// The tick is registered so downstream logic sees a clean single-cycle pulse.
module ms_tick #(
    parameter int CLK_HZ = 76800000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    // Clocks per millisecond, never below one so tiny sim clocks still tick.
    localparam int DIV = ((CLK_HZ / 1000) > 1) ? (CLK_HZ / 1000) : 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    // Count 0..DIV-1 and pulse tick on the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/atu_tune_seq.sv
// ATU tune sequencer: turns a host tune command into the tuner start/key
// handshake, requests a low-power carrier while the tuner is busy, and
// reports the outcome on status.
// Optional feature: define ATU_DEBOUNCE_EN to debounce the tuner key line
// for DEBOUNCE_MS ticks; without it the synchronized line is used directly.
module atu_tune_seq
    import atu_pkg::*;
#(
    parameter int CLK_HZ          = 76800000,
    parameter int START_MS        = 500,
    parameter int ACK_TIMEOUT_MS  = 1000,
    parameter int TUNE_TIMEOUT_MS = 15000,
    parameter int COOLDOWN_MS     = 100,
    parameter int DEBOUNCE_MS     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    atu_tune_seq_if.slave  bus
);

    localparam ms_cnt_t START_LIM = ms_limit(START_MS);
    localparam ms_cnt_t ACK_LIM   = ms_limit(ACK_TIMEOUT_MS);
    localparam ms_cnt_t TUNE_LIM  = ms_limit(TUNE_TIMEOUT_MS);
    localparam ms_cnt_t COOL_LIM  = ms_limit(COOLDOWN_MS);

    logic    ms_tick_pulse;
    logic    ack_meta;
    logic    ack_sync;
    logic    ack_s;
    logic    stop_req;

    state_t  state;
    ms_cnt_t ms_cnt;
    logic    atu_req_q;
    logic    tx_tune_en_q;
    logic    busy_q;
    status_t status_q;

    ms_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (ms_tick_pulse)
    );

    // Two-flop synchronizer for the asynchronous key line; idles released (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= 1'b1;
            ack_sync <= 1'b1;
        end else begin
            ack_meta <= bus.atu_ack;
            ack_sync <= ack_meta;
        end
    end

`ifdef ATU_DEBOUNCE_EN
    localparam ms_cnt_t DEB_LIM = ms_limit(DEBOUNCE_MS);

    logic    ack_deb;
    ms_cnt_t deb_cnt;

    // Follow the synchronized line only once it has disagreed for DEBOUNCE_MS ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_deb <= 1'b1;
            deb_cnt <= '0;
        end else if (ack_sync == ack_deb) begin
            deb_cnt <= '0;
        end else if (ms_tick_pulse) begin
            if (deb_cnt >= DEB_LIM) begin
                ack_deb <= ack_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= ms_sat_inc(deb_cnt);
            end
        end
    end

    assign ack_s = ack_deb;
`else
    logic unused_debounce_ms;

    assign ack_s              = ack_sync;
    assign unused_debounce_ms = ^DEBOUNCE_MS;
`endif

    // Abort and external inhibit both cut an active cycle short.
    assign stop_req = bus.tune_abort | bus.tx_inhibit;

    // Sequencer FSM with registered outputs; the ms counter restarts on each state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ms_cnt       <= '0;
            atu_req_q    <= 1'b1;
            tx_tune_en_q <= 1'b0;
            busy_q       <= 1'b0;
            status_q     <= ST_NONE;
        end else begin
            if (ms_tick_pulse) begin
                ms_cnt <= ms_sat_inc(ms_cnt);
            end

            case (state)
                IDLE: begin
                    ms_cnt <= '0;
                    if (bus.tune_abort) begin
                        state <= IDLE;
                    end else if (bus.tune_start && bus.tx_inhibit) begin
                        status_q <= ST_ABORT;
                    end else if (bus.tune_start) begin
                        state     <= START;
                        status_q  <= ST_NONE;
                        atu_req_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                START: begin
                    if (stop_req) begin
                        state        <= COOL;
                        ms_cnt       <= '0;
                        atu_req_q    <= 1'b1;
                        tx_tune_en_q <= 1'b0;
                        status_q     <= ST_ABORT;
                    end else if (ms_tick_pulse && (ms_cnt >= START_LIM)) begin
                        state     <= WAIT_ACK;
                        ms_cnt    <= '0;
                        atu_req_q <= 1'b1;
                    end
                end

                WAIT_ACK: begin
                    if (stop_req) begin
                        state        <= COOL;
                        ms_cnt       <= '0;
                        atu_req_q    <= 1'b1;
                        tx_tune_en_q <= 1'b0;
                        status_q     <= ST_ABORT;
                    end else if (!ack_s) begin
                        state        <= TUNE;
                        ms_cnt       <= '0;
                        tx_tune_en_q <= 1'b1;
                    end else if (ms_tick_pulse && (ms_cnt >= ACK_LIM)) begin
                        state    <= COOL;
                        ms_cnt   <= '0;
                        status_q <= ST_TIMEOUT;
                    end
                end

                TUNE: begin
                    if (stop_req) begin
                        state        <= COOL;
                        ms_cnt       <= '0;
                        atu_req_q    <= 1'b1;
                        tx_tune_en_q <= 1'b0;
                        status_q     <= ST_ABORT;
                    end else if (ack_s) begin
                        state        <= COOL;
                        ms_cnt       <= '0;
                        tx_tune_en_q <= 1'b0;
                        status_q     <= ST_OK;
                    end else if (ms_tick_pulse && (ms_cnt >= TUNE_LIM)) begin
                        state        <= COOL;
                        ms_cnt       <= '0;
                        tx_tune_en_q <= 1'b0;
                        status_q     <= ST_TIMEOUT;
                    end
                end

                COOL: begin
                    atu_req_q    <= 1'b1;
                    tx_tune_en_q <= 1'b0;
                    if (ms_tick_pulse && (ms_cnt >= COOL_LIM)) begin
                        state  <= IDLE;
                        ms_cnt <= '0;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state        <= IDLE;
                    ms_cnt       <= '0;
                    atu_req_q    <= 1'b1;
                    tx_tune_en_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.atu_req    = atu_req_q;
    assign bus.tx_tune_en = tx_tune_en_q;
    assign bus.busy       = busy_q;
    assign bus.status     = status_q;

endmodule

// File: tb/tb_atu_tune_seq.sv
// Testbench for atu_tune_seq with a 4-clock millisecond (CLK_HZ=4000).
// A table of tuner-response vectors runs full tune cycles; hand-written
// sequences cover abort, inhibit, cooldown, pre-asserted key and async reset.
// Build with ATU_DEBOUNCE_EN to run the debounce vectors instead.
module tb_atu_tune_seq;

    typedef struct {
        string      name;
        int         ack_delay;
        int         ack_len;
        logic [1:0] exp_status;
        int         tx_min;
        int         tx_max;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t vecs[$];

    atu_tune_seq_if bus();

    atu_tune_seq #(
        .CLK_HZ          (4000),
        .START_MS        (5),
        .ACK_TIMEOUT_MS  (10),
        .TUNE_TIMEOUT_MS (20),
        .COOLDOWN_MS     (3),
        .DEBOUNCE_MS     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10-unit clock; outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something hangs outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic start, input logic abort,
                                  input logic inhibit, input logic ack);
        bus.tune_start = start;
        bus.tune_abort = abort;
        bus.tx_inhibit = inhibit;
        bus.atu_ack    = ack;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return bus.atu_req;
            1:       return bus.tx_tune_en;
            default: return bus.busy;
        endcase
    endfunction

    // Wait on falling edges until the chosen output reaches val; expiry counts as a failure.
    task automatic wait_for(input string name, input int which, input logic val, input int budget);
        int n;
        n = 0;
        while (probe(which) !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (probe(which) !== val) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: got %0b after %0d cycles, expected %0b", name, probe(which), n, val);
        end
    endtask

    task automatic pulse_start();
        bus.tune_start = 1'b1;
        @(negedge clk);
        bus.tune_start = 1'b0;
    endtask

    // One full tune cycle driven by a vector: start, key response, completion.
    task automatic run_vector(input vec_t v);
        int  width;
        int  tx_cnt;
        bit  done;
        pulse_start();
        check_output({v.name, " req latency"}, bus.atu_req, 0);
        check_output({v.name, " busy on start"}, bus.busy, 1);
        check_output({v.name, " status cleared"}, bus.status, 0);
        width = 0;
        while (bus.atu_req == 1'b0 && width < 100) begin
            width++;
            @(negedge clk);
        end
        check_range({v.name, " req low width"}, width, 17, 20);
        tx_cnt = 0;
        done   = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            bus.atu_ack = !(c >= v.ack_delay && c < v.ack_delay + v.ack_len);
            @(negedge clk);
            if (bus.tx_tune_en) tx_cnt++;
            if (!bus.busy) done = 1'b1;
        end
        check_output({v.name, " cycle completed"}, int'(done), 1);
        check_output({v.name, " status"}, bus.status, int'(v.exp_status));
        check_range({v.name, " tx_tune_en cycles"}, tx_cnt, v.tx_min, v.tx_max);
        bus.atu_ack = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

`ifdef ATU_DEBOUNCE_EN
        vecs.push_back('{name: "glitch 2ms",  ack_delay: 0, ack_len: 8,  exp_status: 2'd2, tx_min: 0,  tx_max: 0});
        vecs.push_back('{name: "held 6ms",    ack_delay: 0, ack_len: 24, exp_status: 2'd1, tx_min: 19, tx_max: 29});
`else
        vecs.push_back('{name: "normal",      ack_delay: 8,  ack_len: 32,     exp_status: 2'd1, tx_min: 31, tx_max: 33});
        vecs.push_back('{name: "no tuner",    ack_delay: 0,  ack_len: 0,      exp_status: 2'd2, tx_min: 0,  tx_max: 0});
        vecs.push_back('{name: "stuck tuner", ack_delay: 0,  ack_len: 100000, exp_status: 2'd2, tx_min: 77, tx_max: 80});
        vecs.push_back('{name: "short tune",  ack_delay: 24, ack_len: 16,     exp_status: 2'd1, tx_min: 15, tx_max: 17});
        vecs.push_back('{name: "late ack",    ack_delay: 48, ack_len: 16,     exp_status: 2'd2, tx_min: 0,  tx_max: 0});
        vecs.push_back('{name: "blip ack",    ack_delay: 4,  ack_len: 4,      exp_status: 2'd1, tx_min: 3,  tx_max: 5});
`endif

        // Reset values
        rst_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_output("reset atu_req", bus.atu_req, 1);
        check_output("reset tx_tune_en", bus.tx_tune_en, 0);
        check_output("reset busy", bus.busy, 0);
        check_output("reset status", bus.status, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vector(vecs[i]);
        end

`ifndef ATU_DEBOUNCE_EN
        // Start while inhibited in IDLE: refused with abort status
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_output("inhibit idle status", bus.status, 3);
        check_output("inhibit idle req", bus.atu_req, 1);
        check_output("inhibit idle busy", bus.busy, 0);

        // Start and abort together in IDLE: abort wins
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_output("start+abort busy", bus.busy, 0);
        check_output("start+abort req", bus.atu_req, 1);

        // Abort mid-TUNE, start ignored in COOL, accepted after
        pulse_start();
        wait_for("abort: req release", 0, 1'b1, 40);
        bus.atu_ack = 1'b0;
        wait_for("abort: tune entered", 1, 1'b1, 20);
        repeat (5) @(negedge clk);
        bus.tune_abort = 1'b1;
        @(negedge clk);
        bus.tune_abort = 1'b0;
        bus.atu_ack    = 1'b1;
        check_output("abort tx_tune_en", bus.tx_tune_en, 0);
        check_output("abort atu_req", bus.atu_req, 1);
        check_output("abort status", bus.status, 3);
        check_output("abort busy in cool", bus.busy, 1);
        pulse_start();
        check_output("cool start req", bus.atu_req, 1);
        check_output("cool start status", bus.status, 3);
        wait_for("cool end", 2, 1'b0, 40);
        pulse_start();
        check_output("post-cool start req", bus.atu_req, 0);
        check_output("post-cool start status", bus.status, 0);
        wait_for("post-cool cycle end", 2, 1'b0, 200);

        // Inhibit during START
        pulse_start();
        repeat (3) @(negedge clk);
        bus.tx_inhibit = 1'b1;
        @(negedge clk);
        bus.tx_inhibit = 1'b0;
        check_output("inhibit start req", bus.atu_req, 1);
        check_output("inhibit start status", bus.status, 3);
        check_output("inhibit start busy", bus.busy, 1);
        wait_for("inhibit cycle end", 2, 1'b0, 40);

        // Key already low when WAIT_ACK is entered: TUNE on the next cycle
        bus.atu_ack = 1'b0;
        repeat (3) @(negedge clk);
        pulse_start();
        wait_for("prelow req release", 0, 1'b1, 40);
        check_output("prelow tx at release", bus.tx_tune_en, 0);
        @(negedge clk);
        check_output("prelow tx next cycle", bus.tx_tune_en, 1);
        bus.atu_ack = 1'b1;
        wait_for("prelow cycle end", 2, 1'b0, 60);
        check_output("prelow status", bus.status, 1);

        // Asynchronous reset mid-TUNE
        pulse_start();
        wait_for("reset: req release", 0, 1'b1, 40);
        bus.atu_ack = 1'b0;
        wait_for("reset: tune entered", 1, 1'b1, 20);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async reset tx_tune_en", bus.tx_tune_en, 0);
        check_output("async reset atu_req", bus.atu_req, 1);
        check_output("async reset busy", bus.busy, 0);
        check_output("async reset status", bus.status, 0);
        @(negedge clk);
        bus.atu_ack = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
